// File: rtl/craft_round_ctrl.sv
// Round sequencer for the nibble-serial CRAFT datapath: LOAD, ROUND x (NUM_ROUNDS-1), FINAL, UNLOAD.
// Optional feature: define CRAFT_CTRL_ABORT_EN to add an 'abort' input that cancels a run.
module craft_round_ctrl #(
   parameter int NUM_ROUNDS = 32,
   parameter int NIBBLES    = 16,
   parameter int RW         = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
`ifdef CRAFT_CTRL_ABORT_EN
   input  logic          abort,
`endif
   output logic          load_en,
   output logic          round_en,
   output logic [3:0]    nib_idx,
   output logic [RW-1:0] round,
   output logic          cm0,
   output logic          cm1,
   output logic          ck0,
   output logic          sb_bypass,
   output logic          out_valid,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      ROUND  = 3'd2,
      FINAL  = 3'd3,
      UNLOAD = 3'd4
   } state_t;

   localparam logic [3:0]    LAST_NIB  = 4'(NIBBLES - 1);
   localparam logic [RW-1:0] FINAL_RND = RW'(NUM_ROUNDS - 1);

   state_t          state, state_next;
   logic [3:0]      nib_next;
   logic [RW-1:0]   round_next;
   logic [RW-1:0]   round_inc;
   logic            done_next;
   logic            last_nib;
   logic            cancel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         nib_idx <= 4'd0;
         round   <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         nib_idx <= nib_next;
         round   <= round_next;
         done    <= done_next;
      end
   end

   assign last_nib  = (nib_idx == LAST_NIB);
   assign round_inc = round + RW'(1);

`ifdef CRAFT_CTRL_ABORT_EN
   assign cancel = abort && (state != IDLE);
`else
   assign cancel = 1'b0;
`endif

   always_comb begin
      state_next = state;
      nib_next   = nib_idx;
      round_next = round;
      done_next  = 1'b0;
      load_en    = 1'b0;
      round_en   = 1'b0;
      sb_bypass  = 1'b0;
      out_valid  = 1'b0;
      cm0        = 1'b0;
      cm1        = 1'b0;
      ck0        = 1'b0;
      busy       = (state != IDLE);

      if (state != IDLE)
         nib_next = last_nib ? 4'd0 : nib_idx + 4'd1;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
               nib_next   = 4'd0;
               round_next = '0;
            end
         end
         LOAD: begin
            load_en = 1'b1;
            if (last_nib)
               state_next = ROUND;
         end
         ROUND: begin
            round_en = 1'b1;
            if (last_nib) begin
               round_next = round_inc;
               if (round_inc == FINAL_RND)
                  state_next = FINAL;
            end
         end
         FINAL: begin
            round_en  = 1'b1;
            sb_bypass = 1'b1;
            if (last_nib)
               state_next = UNLOAD;
         end
         UNLOAD: begin
            out_valid = 1'b1;
            if (last_nib) begin
               state_next = IDLE;
               round_next = '0;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            nib_next   = 4'd0;
            round_next = '0;
         end
      endcase

      // Row-major order: the first two rows go through MixColumns, row 0 also gets the constant.
      if (state == ROUND || state == FINAL) begin
         cm0 = (nib_idx < 4'd8);
         cm1 = (nib_idx < 4'd4);
         ck0 = (nib_idx == 4'd0);
      end

      if (cancel) begin
         state_next = IDLE;
         nib_next   = 4'd0;
         round_next = '0;
         done_next  = 1'b0;
      end
   end

endmodule

// File: tb/tb_craft_round_ctrl.sv
// Directed table-driven bench for craft_round_ctrl (default build and NUM_ROUNDS=4 instance).
module tb_craft_round_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
`ifdef CRAFT_CTRL_ABORT_EN
   logic       abort;
`endif

   logic       load_en, round_en, cm0, cm1, ck0, sb_bypass, out_valid, busy, done;
   logic [3:0] nib_idx;
   logic [7:0] round;

   logic       load_en4, round_en4, cm04, cm14, ck04, sb4, ov4, busy4, done4;
   logic [3:0] nib4;
   logic [7:0] round4;

   int applied = 0;
   int miscompares = 0;

   typedef struct {
      int          cyc;
      logic [20:0] exp;
   } vec_t;

   vec_t vecs[17];

   always #5 clk = ~clk;

   craft_round_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CRAFT_CTRL_ABORT_EN
      .abort(abort),
`endif
      .load_en(load_en), .round_en(round_en), .nib_idx(nib_idx), .round(round),
      .cm0(cm0), .cm1(cm1), .ck0(ck0), .sb_bypass(sb_bypass),
      .out_valid(out_valid), .busy(busy), .done(done)
   );

   craft_round_ctrl #(.NUM_ROUNDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CRAFT_CTRL_ABORT_EN
      .abort(abort),
`endif
      .load_en(load_en4), .round_en(round_en4), .nib_idx(nib4), .round(round4),
      .cm0(cm04), .cm1(cm14), .ck0(ck04), .sb_bypass(sb4),
      .out_valid(ov4), .busy(busy4), .done(done4)
   );

   function automatic vec_t mk(int c, int le, int re, int n, int r, int c0, int c1,
                               int k0, int sb, int ov, int bz, int dn);
      vec_t v;
      v.cyc = c;
      v.exp = {le[0], re[0], n[3:0], r[7:0], c0[0], c1[0], k0[0], sb[0], ov[0], bz[0], dn[0]};
      return v;
   endfunction

   function automatic logic [20:0] obs();
      return {load_en, round_en, nib_idx, round, cm0, cm1, ck0, sb_bypass, out_valid, busy, done};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Caller sets start=1 before calling; edge 0 is the first edge inside.
   task automatic applyStimulus(input bit holdStart);
      int nLoad = 0, nRound = 0, nSb = 0, nOv = 0, nBusy = 0, nDone = 0;
      int doneAt = 0, d4DoneAt = 0;
      stepEdge();
      if (!holdStart) start = 1'b0;
      for (int k = 1; k <= 545; k++) begin
         foreach (vecs[i])
            if (vecs[i].cyc == k)
               checkOutput($sformatf("vec@%0d", k), 32'(obs()), 32'(vecs[i].exp));
         if (k == 49) checkOutput("r4@49", {21'd0, round_en4, sb4, ov4, round4}, {21'd0, 3'b100, 8'd2});
         if (k == 65) checkOutput("r4@65", {21'd0, round_en4, sb4, ov4, round4}, {21'd0, 3'b110, 8'd3});
         if (k == 81) checkOutput("r4@81", {21'd0, round_en4, sb4, ov4, round4}, {21'd0, 3'b001, 8'd3});
         nLoad  += int'(load_en);
         nRound += int'(round_en);
         nSb    += int'(sb_bypass);
         nOv    += int'(out_valid);
         nBusy  += int'(busy);
         nDone  += int'(done);
         if (done && doneAt == 0) doneAt = k;
         if (done4 && d4DoneAt == 0) d4DoneAt = k;
         stepEdge();
      end
      checkOutput("load_cycles",  nLoad,  16);
      checkOutput("round_cycles", nRound, 512);
      checkOutput("bypass_cycles", nSb,   16);
      checkOutput("unload_cycles", nOv,   16);
      checkOutput("busy_cycles",  nBusy,  544);
      checkOutput("done_count",   nDone,  1);
      checkOutput("done_cycle",   doneAt, 545);
      checkOutput("done4_cycle",  d4DoneAt, 97);
      if (holdStart)
         checkOutput("restart@546", 32'(obs()), 32'(mk(0, 1,0,0,0, 0,0,0,0,0,1,0).exp));
      else
         checkOutput("idle@546", 32'(obs()), 32'd0);
   endtask

   initial begin
      vecs[0]  = mk(1,   1,0, 0, 0, 0,0,0,0,0,1,0);
      vecs[1]  = mk(16,  1,0,15, 0, 0,0,0,0,0,1,0);
      vecs[2]  = mk(17,  0,1, 0, 0, 1,1,1,0,0,1,0);
      vecs[3]  = mk(20,  0,1, 3, 0, 1,1,0,0,0,1,0);
      vecs[4]  = mk(21,  0,1, 4, 0, 1,0,0,0,0,1,0);
      vecs[5]  = mk(24,  0,1, 7, 0, 1,0,0,0,0,1,0);
      vecs[6]  = mk(25,  0,1, 8, 0, 0,0,0,0,0,1,0);
      vecs[7]  = mk(32,  0,1,15, 0, 0,0,0,0,0,1,0);
      vecs[8]  = mk(33,  0,1, 0, 1, 1,1,1,0,0,1,0);
      vecs[9]  = mk(193, 0,1, 0,11, 1,1,1,0,0,1,0);
      vecs[10] = mk(512, 0,1,15,30, 0,0,0,0,0,1,0);
      vecs[11] = mk(513, 0,1, 0,31, 1,1,1,1,0,1,0);
      vecs[12] = mk(522, 0,1, 9,31, 0,0,0,1,0,1,0);
      vecs[13] = mk(528, 0,1,15,31, 0,0,0,1,0,1,0);
      vecs[14] = mk(529, 0,0, 0,31, 0,0,0,0,1,1,0);
      vecs[15] = mk(544, 0,0,15,31, 0,0,0,0,1,1,0);
      vecs[16] = mk(545, 0,0, 0, 0, 0,0,0,0,0,0,1);

      rst_n = 1'b0;
      start = 1'b0;
`ifdef CRAFT_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) stepEdge();
      checkOutput("reset_state", 32'(obs()), 32'd0);
      rst_n = 1'b1;
      stepEdge();

      // Start held high for a whole run, then still high in the done cycle.
      start = 1'b1;
      applyStimulus(1'b1);
      start = 1'b0;

      begin
         bit found = 1'b0;
         for (int n = 0; n < 200 && !found; n++) begin
            if (round_en && round == 8'd5) found = 1'b1;
            else stepEdge();
         end
         checkOutput("reach_round5", 32'(found), 32'd1);
      end
      #2 rst_n = 1'b0;
      #1 checkOutput("async_reset", 32'(obs()), 32'd0);
      begin
         int nDone = 0;
         for (int n = 0; n < 4; n++) begin
            stepEdge();
            nDone += int'(done);
         end
         rst_n = 1'b1;
         for (int n = 0; n < 3; n++) begin
            stepEdge();
            nDone += int'(done) + int'(busy);
         end
         checkOutput("reset_no_done", nDone, 0);
      end

      start = 1'b1;
      applyStimulus(1'b0);

`ifdef CRAFT_CTRL_ABORT_EN
      start = 1'b1;
      stepEdge();
      start = 1'b0;
      begin
         bit found = 1'b0;
         int nDone = 0;
         for (int n = 0; n < 400 && !found; n++) begin
            if (round_en && round == 8'd10) found = 1'b1;
            else stepEdge();
         end
         checkOutput("reach_round10", 32'(found), 32'd1);
         abort = 1'b1;
         stepEdge();
         abort = 1'b0;
         checkOutput("abort_idle", 32'(obs()), 32'd0);
         for (int n = 0; n < 20; n++) begin
            stepEdge();
            nDone += int'(done) + int'(busy);
         end
         checkOutput("abort_no_done", nDone, 0);
         abort = 1'b1;
         start = 1'b1;
         stepEdge();
         abort = 1'b0;
         start = 1'b0;
         checkOutput("abort_ignored_idle", {31'd0, load_en}, 32'd1);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
